// File: rtl/heartbeat_tx.sv
// Heartbeat transmitter: snapshots the epoch count on each accepted tick and sends it as a HI/LO word pair.
// Latency: first word is valid the cycle after the accepted tick; back-to-back packets follow with no bubble.
// Backpressure: up_d holds while up_v && !up_a; one pending tick is buffered, newer ticks overwrite it and count an overrun.
module heartbeat_tx #(
    parameter int         Ntime  = 32,
    parameter logic [3:0] CodeHi = 4'hB,
    parameter logic [3:0] CodeLo = 4'hA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  epoch_tick,
    input  logic [Ntime-1:0]      epochs_elapsed,
    input  logic                  reset_time,
    output logic                  up_v,
    output logic [4+Ntime/2-1:0]  up_d,
    input  logic                  up_a,
    output logic                  busy,
    output logic [7:0]            overrun_count
);

    localparam int HW = Ntime / 2;

    typedef struct packed {
        logic [3:0]    code;
        logic [HW-1:0] payload;
    } word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    state_t           state;
    word_t            word_q;
    logic [HW-1:0]    snap_lo;
    logic             pend_vld;
    logic [Ntime-1:0] pend_dat;
    logic             hi_valid;
    logic [HW-1:0]    last_hi;

    logic             tick;
    logic             xfer;
    logic             pend_live;
    logic             hv_live;
    logic             hi_done;
    logic             lo_done;
    logic             load_tick;
    logic             load_pend;
    logic             park_tick;
    logic             bump;
    logic [Ntime-1:0] load_val;
    logic             skip_hi;

    assign up_v = (state != IDLE);
    assign busy = up_v;
    assign up_d = word_q;

    always_comb begin
        tick      = epoch_tick & enable;
        xfer      = up_v & up_a;
        // A wall-clock reset invalidates the pending snapshot and the HI cache before this cycle's tick is considered.
        pend_live = pend_vld & ~reset_time;
        hv_live   = hi_valid & ~reset_time;
        hi_done   = (state == SEND_HI) & xfer;
        lo_done   = (state == SEND_LO) & xfer;
        load_tick = tick & ((state == IDLE) | lo_done);
        load_pend = lo_done & ~tick & pend_live;
        park_tick = tick & ~load_tick;
        bump      = tick & pend_live & (state != IDLE);
        load_val  = load_tick ? epochs_elapsed : pend_dat;
        skip_hi   = hv_live & (load_val[Ntime-1:HW] == last_hi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            word_q        <= '0;
            snap_lo       <= '0;
            pend_vld      <= 1'b0;
            pend_dat      <= '0;
            hi_valid      <= 1'b0;
            last_hi       <= '0;
            overrun_count <= '0;
        end else begin
            if (bump && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            // Leaving SEND_LO always empties pending: it is either loaded, superseded by the tick, or already empty.
            if (park_tick) begin
                pend_vld <= 1'b1;
                pend_dat <= epochs_elapsed;
            end else if (lo_done || reset_time) begin
                pend_vld <= 1'b0;
            end

            if (hi_done) begin
                last_hi  <= word_q.payload;
                hi_valid <= ~reset_time;
            end else if (reset_time) begin
                hi_valid <= 1'b0;
            end

            if (load_tick || load_pend) begin
                snap_lo <= load_val[HW-1:0];
                if (skip_hi) begin
                    state  <= SEND_LO;
                    word_q <= '{code: CodeLo, payload: load_val[HW-1:0]};
                end else begin
                    state  <= SEND_HI;
                    word_q <= '{code: CodeHi, payload: load_val[Ntime-1:HW]};
                end
            end else begin
                case (state)
                    SEND_HI: begin
                        if (xfer) begin
                            state  <= SEND_LO;
                            word_q <= '{code: CodeLo, payload: snap_lo};
                        end
                    end
                    SEND_LO: begin
                        if (xfer) begin
                            state  <= IDLE;
                            word_q <= '0;
                        end
                    end
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_tx.sv
// Randomized and directed bench for heartbeat_tx against a word-queue reference model.
module tb_heartbeat_tx;

    localparam int NT = 32;
    localparam int W  = 4 + NT / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          epoch_tick;
    logic [NT-1:0] epochs_elapsed;
    logic          reset_time;
    logic          up_v;
    logic [W-1:0]  up_d;
    logic          up_a;
    logic          busy;
    logic [7:0]    overrun_count;

    int checks = 0;
    int errors = 0;

    heartbeat_tx #(.Ntime(NT), .CodeHi(4'hB), .CodeLo(4'hA)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .epoch_tick     (epoch_tick),
        .epochs_elapsed (epochs_elapsed),
        .reset_time     (reset_time),
        .up_v           (up_v),
        .up_d           (up_d),
        .up_a           (up_a),
        .busy           (busy),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: the words still owed for the current packet, plus pending/HI-cache/overrun bookkeeping.
    logic [W-1:0]  mq[$];
    logic          m_pv;
    logic [NT-1:0] m_pend;
    logic          m_hv;
    logic [15:0]   m_last;
    int            m_ovr;

    task automatic build(input logic [NT-1:0] s, input logic hv);
        if (!(hv && s[31:16] == m_last))
            mq.push_back({4'hB, s[31:16]});
        mq.push_back({4'hA, s[15:0]});
    endtask

    task automatic bump_ovr();
        if (m_ovr < 255) m_ovr++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic tk, pv, hv;
        if (reset) begin
            mq.delete();
            m_pv = 0; m_pend = '0; m_hv = 0; m_last = '0; m_ovr = 0;
        end else begin
            tk = epoch_tick && enable;
            pv = m_pv && !reset_time;
            hv = m_hv && !reset_time;
            if (mq.size() == 0) begin
                if (tk) build(epochs_elapsed, hv);
            end else if (up_a && mq.size() == 2) begin
                m_last = mq[0][15:0];
                hv = !reset_time;
                void'(mq.pop_front());
                if (tk) begin
                    if (pv) bump_ovr();
                    m_pend = epochs_elapsed; pv = 1;
                end
            end else if (up_a) begin
                void'(mq.pop_front());
                if (tk) begin
                    if (pv) bump_ovr();
                    pv = 0;
                    build(epochs_elapsed, hv);
                end else if (pv) begin
                    pv = 0;
                    build(m_pend, hv);
                end
            end else if (tk) begin
                if (pv) bump_ovr();
                m_pend = epochs_elapsed; pv = 1;
            end
            m_pv = pv; m_hv = hv;
        end
        #1;
        check("up_v", {31'd0, up_v}, {31'd0, mq.size() != 0});
        check("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
        check("overrun_count", {24'd0, overrun_count}, m_ovr);
        if (mq.size() != 0)
            check("up_d", {12'd0, up_d}, {12'd0, mq[0]});
    end

    task automatic drive(input logic et, input logic [NT-1:0] ep, input logic rt, input logic a);
        epoch_tick = et; epochs_elapsed = ep; reset_time = rt; up_a = a;
        @(negedge clk);
    endtask

    initial begin
        reset = 1; enable = 1; epoch_tick = 0; epochs_elapsed = '0; reset_time = 0; up_a = 0;
        @(negedge clk);
        drive(0, 0, 0, 0);
        check("rst_up_v", {31'd0, up_v}, 0);
        check("rst_up_d", {12'd0, up_d}, 0);
        check("rst_ovr", {24'd0, overrun_count}, 0);
        reset = 0;

        // Basic packet, then HI suppression, then HI resent after a wall-clock reset.
        drive(1, 32'h0001_0005, 0, 1); check("p1_hi", {12'd0, up_d}, 32'h000B_0001);
        drive(0, 0, 0, 1);             check("p1_lo", {12'd0, up_d}, 32'h000A_0005);
        drive(0, 0, 0, 1);             check("p1_end", {31'd0, up_v}, 0);
        drive(1, 32'h0001_0006, 0, 1); check("p2_lo_only", {12'd0, up_d}, 32'h000A_0006);
        drive(0, 0, 0, 1);             check("p2_end", {31'd0, up_v}, 0);
        drive(0, 0, 1, 1);
        drive(1, 32'h0001_0007, 0, 1); check("p3_hi", {12'd0, up_d}, 32'h000B_0001);
        drive(0, 0, 0, 1);             check("p3_lo", {12'd0, up_d}, 32'h000A_0007);
        drive(0, 0, 0, 1);

        // Stalled link: first word held, pending overwritten once.
        drive(1, 32'h10, 0, 0);
        drive(1, 32'h11, 0, 0);
        drive(1, 32'h12, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0);
        check("stall_hold", {12'd0, up_d}, 32'h000B_0000);
        check("stall_ovr", {24'd0, overrun_count}, 1);
        drive(0, 0, 0, 1); check("stall_lo", {12'd0, up_d}, 32'h000A_0010);
        drive(0, 0, 0, 1); check("pend_next", {12'd0, up_d}, 32'h000A_0012);
        drive(0, 0, 0, 1); check("pend_end", {31'd0, up_v}, 0);

        // Tick coincident with the LO ack while pending is full.
        drive(1, 32'h20, 0, 0);
        drive(1, 32'h21, 0, 0);
        drive(1, 32'h22, 0, 0);
        drive(1, 32'h23, 0, 1);
        check("coin_word", {12'd0, up_d}, 32'h000A_0023);
        check("coin_ovr", {24'd0, overrun_count}, 3);
        drive(0, 0, 0, 1); check("coin_end", {31'd0, up_v}, 0);

        // Saturation of the overrun counter.
        drive(1, 32'h30, 0, 0);
        for (int i = 0; i < 301; i++) drive(1, 32'h31 + i, 0, 0);
        check("ovr_sat", {24'd0, overrun_count}, 255);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);

        enable = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h40 + i, 0, 1);
            check("disabled", {31'd0, up_v}, 0);
        end
        enable = 1;

        drive(1, 32'h0005_0001, 0, 0); check("mid_hi", {12'd0, up_d}, 32'h000B_0005);
        reset = 1;
        drive(0, 0, 0, 0);
        check("mid_rst_v", {31'd0, up_v}, 0);
        check("mid_rst_ovr", {24'd0, overrun_count}, 0);
        reset = 0;

        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 9) < 3,
                  {14'd0, 2'($urandom_range(0, 2)), 16'($urandom)},
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
